// File: rtl/unified_buffer_arbiter_pkg.sv
// Shared types and constants for the unified buffer arbiter slice.
// Also holds the saturating-increment helper used by the optional statistics counters.
package tpu_package;

  localparam int UB_ADDR_W = 12;
  localparam int UB_DATA_W = 256;

  typedef enum logic [1:0] {
    UB_GNT_NONE,
    UB_GNT_RD,
    UB_GNT_HW,
    UB_GNT_AW
  } ub_gnt_t;

  function automatic logic [31:0] satInc32(input logic [31:0] value, input logic en);
    return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/unified_buffer_arbiter_write_rr.sv
// Two-writer round-robin pointer plus per-writer starvation counters.
// write_sel_o picks the writer that should win a write slot; starved_o demands that slot now.
module ub_write_rr_arbiter
  import tpu_package::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hw_req_i,
  input  logic aw_req_i,
  input  logic hw_gnt_i,
  input  logic aw_gnt_i,
  output logic write_sel_o,
  output logic starved_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic             rrPtr_q, rrPtr_d;
  logic [CNT_W-1:0] hwCnt_q, hwCnt_d;
  logic [CNT_W-1:0] awCnt_q, awCnt_d;
  logic             hwStarved, awStarved;

  // A saturated count only matters while that writer is still asking.
  assign hwStarved = hw_req_i && (hwCnt_q == CNT_MAX);
  assign awStarved = aw_req_i && (awCnt_q == CNT_MAX);
  assign starved_o = hwStarved || awStarved;

  always_comb begin
    write_sel_o = rrPtr_q;
    if (hwStarved && awStarved) begin
      write_sel_o = rrPtr_q;
    end else if (hwStarved) begin
      write_sel_o = 1'b0;
    end else if (awStarved) begin
      write_sel_o = 1'b1;
    end else if (hw_req_i && aw_req_i) begin
      write_sel_o = rrPtr_q;
    end else if (aw_req_i) begin
      write_sel_o = 1'b1;
    end else begin
      write_sel_o = 1'b0;
    end
  end

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (hw_gnt_i) begin
      rrPtr_d = 1'b1;
    end else if (aw_gnt_i) begin
      rrPtr_d = 1'b0;
    end

    hwCnt_d = hwCnt_q;
    if (!hw_req_i || hw_gnt_i) begin
      hwCnt_d = '0;
    end else if (hwCnt_q != CNT_MAX) begin
      hwCnt_d = hwCnt_q + 1'b1;
    end

    awCnt_d = awCnt_q;
    if (!aw_req_i || aw_gnt_i) begin
      awCnt_d = '0;
    end else if (awCnt_q != CNT_MAX) begin
      awCnt_d = awCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rrPtr_q <= 1'b0;
      hwCnt_q <= '0;
      awCnt_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
      hwCnt_q <= hwCnt_d;
      awCnt_q <= awCnt_d;
    end
  end

endmodule

// File: rtl/unified_buffer_arbiter.sv
// Single-port unified buffer arbiter: feed reads first, round-robin writers, starvation override.
// Define UB_ARB_STATS_EN to add saturating stall/forced-grant statistics outputs.
module unified_buffer_arbiter
  import tpu_package::*;
#(
  parameter int ADDR_W   = UB_ADDR_W,
  parameter int DATA_W   = UB_DATA_W,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_gnt_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              hw_req_i,
  input  logic [ADDR_W-1:0] hw_addr_i,
  input  logic [DATA_W-1:0] hw_data_i,
  output logic              hw_gnt_o,
  input  logic              aw_req_i,
  input  logic [ADDR_W-1:0] aw_addr_i,
  input  logic [DATA_W-1:0] aw_data_i,
  output logic              aw_gnt_o,
  output logic              ub_en_o,
  output logic              ub_we_o,
  output logic [ADDR_W-1:0] ub_addr_o,
  output logic [DATA_W-1:0] ub_wdata_o,
  input  logic [DATA_W-1:0] ub_rdata_i
`ifdef UB_ARB_STATS_EN
  ,
  output logic [31:0]       stat_rd_stall_o,
  output logic [31:0]       stat_wr_stall_o,
  output logic [31:0]       stat_forced_o
`endif
);

  logic        writeSel, starved;
  ub_gnt_t     gntSel;

  logic              ubEn_q, ubEn_d;
  logic              ubWe_q, ubWe_d;
  logic [ADDR_W-1:0] ubAddr_q, ubAddr_d;
  logic [DATA_W-1:0] ubWdata_q, ubWdata_d;
  logic [RD_LAT-1:0] rdVld_q, rdVld_d;
  logic [DATA_W-1:0] rdData_q, rdData_d;

  ub_write_rr_arbiter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_write_rr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .hw_req_i   (hw_req_i),
    .aw_req_i   (aw_req_i),
    .hw_gnt_i   (hw_gnt_o),
    .aw_gnt_i   (aw_gnt_o),
    .write_sel_o(writeSel),
    .starved_o  (starved)
  );

  // Starvation beats the feed read; otherwise the read wins over any writer.
  always_comb begin
    gntSel = UB_GNT_NONE;
    if (!rst_i) begin
      gntSel = UB_GNT_NONE;
    end else if (starved) begin
      gntSel = writeSel ? UB_GNT_AW : UB_GNT_HW;
    end else if (rd_req_i) begin
      gntSel = UB_GNT_RD;
    end else if (hw_req_i || aw_req_i) begin
      gntSel = writeSel ? UB_GNT_AW : UB_GNT_HW;
    end
  end

  assign rd_gnt_o = (gntSel == UB_GNT_RD);
  assign hw_gnt_o = (gntSel == UB_GNT_HW);
  assign aw_gnt_o = (gntSel == UB_GNT_AW);

  always_comb begin
    ubEn_d    = (gntSel != UB_GNT_NONE);
    ubWe_d    = hw_gnt_o || aw_gnt_o;
    ubAddr_d  = ubAddr_q;
    ubWdata_d = ubWdata_q;
    case (gntSel)
      UB_GNT_RD: ubAddr_d = rd_addr_i;
      UB_GNT_HW: begin
        ubAddr_d  = hw_addr_i;
        ubWdata_d = hw_data_i;
      end
      UB_GNT_AW: begin
        ubAddr_d  = aw_addr_i;
        ubWdata_d = aw_data_i;
      end
      default: ;
    endcase
  end

  // The valid pipe starts from the registered command, so it lines up with SRAM latency.
  always_comb begin
    rdVld_d    = '0;
    rdVld_d[0] = ubEn_q && !ubWe_q;
    for (int i = 1; i < RD_LAT; i++) begin
      rdVld_d[i] = rdVld_q[i-1];
    end
  end

  assign rd_valid_o = rdVld_q[RD_LAT-1];
  assign rd_data_o  = rd_valid_o ? ub_rdata_i : rdData_q;
  assign rdData_d   = rd_data_o;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ubEn_q    <= 1'b0;
      ubWe_q    <= 1'b0;
      ubAddr_q  <= '0;
      ubWdata_q <= '0;
      rdVld_q   <= '0;
      rdData_q  <= '0;
    end else begin
      ubEn_q    <= ubEn_d;
      ubWe_q    <= ubWe_d;
      ubAddr_q  <= ubAddr_d;
      ubWdata_q <= ubWdata_d;
      rdVld_q   <= rdVld_d;
      rdData_q  <= rdData_d;
    end
  end

  assign ub_en_o    = ubEn_q;
  assign ub_we_o    = ubWe_q;
  assign ub_addr_o  = ubAddr_q;
  assign ub_wdata_o = ubWdata_q;

`ifdef UB_ARB_STATS_EN
  logic [31:0] statRd_q, statWr_q, statForced_q;
  logic        wrPending, wrGranted;

  assign wrPending = hw_req_i || aw_req_i;
  assign wrGranted = hw_gnt_o || aw_gnt_o;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      statRd_q     <= '0;
      statWr_q     <= '0;
      statForced_q <= '0;
    end else begin
      statRd_q     <= satInc32(statRd_q, rd_req_i && !rd_gnt_o);
      statWr_q     <= satInc32(statWr_q, wrPending && !wrGranted);
      statForced_q <= satInc32(statForced_q, wrGranted && starved);
    end
  end

  assign stat_rd_stall_o = statRd_q;
  assign stat_wr_stall_o = statWr_q;
  assign stat_forced_o   = statForced_q;
`endif

endmodule

// File: tb/tb_unified_buffer_arbiter.sv
// Directed self-checking bench for unified_buffer_arbiter with a two-cycle SRAM read model.
// Statistics checks are compiled in only when UB_ARB_STATS_EN is defined.
module tb_unified_buffer_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 256;

  localparam logic [ADDR_W-1:0] HW_ADDR = 12'h100;
  localparam logic [ADDR_W-1:0] AW_ADDR = 12'h200;
  localparam logic [ADDR_W-1:0] NO_ADDR = 12'h000;
  localparam logic [DATA_W-1:0] HW_DATA = {8{32'hA5A5_0001}};
  localparam logic [DATA_W-1:0] AW_DATA = {8{32'h5A5A_0002}};
  localparam logic [DATA_W-1:0] NO_DATA = '0;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              rd_req_i = 1'b0;
  logic [ADDR_W-1:0] rd_addr_i = '0;
  logic              rd_gnt_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_valid_o;
  logic              hw_req_i = 1'b0;
  logic [ADDR_W-1:0] hw_addr_i = '0;
  logic [DATA_W-1:0] hw_data_i = '0;
  logic              hw_gnt_o;
  logic              aw_req_i = 1'b0;
  logic [ADDR_W-1:0] aw_addr_i = '0;
  logic [DATA_W-1:0] aw_data_i = '0;
  logic              aw_gnt_o;
  logic              ub_en_o;
  logic              ub_we_o;
  logic [ADDR_W-1:0] ub_addr_o;
  logic [DATA_W-1:0] ub_wdata_o;
  logic [DATA_W-1:0] ub_rdata_i = '0;
  logic [ADDR_W-1:0] sramStage = '0;
`ifdef UB_ARB_STATS_EN
  logic [31:0]       stat_rd_stall_o;
  logic [31:0]       stat_wr_stall_o;
  logic [31:0]       stat_forced_o;
`endif

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk_i = ~clk_i;

  // SRAM stand-in: returns the commanded address as data two cycles after the command.
  always @(posedge clk_i) begin
    sramStage  <= ub_addr_o;
    ub_rdata_i <= DATA_W'(sramStage);
  end

  unified_buffer_arbiter dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_req_i  (rd_req_i),
    .rd_addr_i (rd_addr_i),
    .rd_gnt_o  (rd_gnt_o),
    .rd_data_o (rd_data_o),
    .rd_valid_o(rd_valid_o),
    .hw_req_i  (hw_req_i),
    .hw_addr_i (hw_addr_i),
    .hw_data_i (hw_data_i),
    .hw_gnt_o  (hw_gnt_o),
    .aw_req_i  (aw_req_i),
    .aw_addr_i (aw_addr_i),
    .aw_data_i (aw_data_i),
    .aw_gnt_o  (aw_gnt_o),
    .ub_en_o   (ub_en_o),
    .ub_we_o   (ub_we_o),
    .ub_addr_o (ub_addr_o),
    .ub_wdata_o(ub_wdata_o),
    .ub_rdata_i(ub_rdata_i)
`ifdef UB_ARB_STATS_EN
    ,
    .stat_rd_stall_o(stat_rd_stall_o),
    .stat_wr_stall_o(stat_wr_stall_o),
    .stat_forced_o  (stat_forced_o)
`endif
  );

  // Each cycle begins 1 time unit after the rising edge, so registered outputs are settled.
  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic rdReq, input logic [ADDR_W-1:0] rdAddr,
                               input logic hwReq, input logic [ADDR_W-1:0] hwAddr,
                               input logic [DATA_W-1:0] hwData, input logic awReq,
                               input logic [ADDR_W-1:0] awAddr, input logic [DATA_W-1:0] awData);
    rst_i     = rst;
    rd_req_i  = rdReq;
    rd_addr_i = rdAddr;
    hw_req_i  = hwReq;
    hw_addr_i = hwAddr;
    hw_data_i = hwData;
    aw_req_i  = awReq;
    aw_addr_i = awAddr;
    aw_data_i = awData;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    nextCycle();
    applyStimulus(1'b0, 1'b0, NO_ADDR, 1'b0, NO_ADDR, NO_DATA, 1'b0, NO_ADDR, NO_DATA);
    nextCycle();
  endtask

  initial begin
    logic expHw, expAw, expRd;

    // Reset with every requester asking: nothing may be granted, all outputs zero.
    applyStimulus(1'b0, 1'b1, 12'h005, 1'b1, HW_ADDR, HW_DATA, 1'b1, AW_ADDR, AW_DATA);
    nextCycle();
    nextCycle();
    checkOutput("rst_rd_gnt", DATA_W'(rd_gnt_o), '0);
    checkOutput("rst_hw_gnt", DATA_W'(hw_gnt_o), '0);
    checkOutput("rst_aw_gnt", DATA_W'(aw_gnt_o), '0);
    checkOutput("rst_ub_en", DATA_W'(ub_en_o), '0);
    checkOutput("rst_ub_we", DATA_W'(ub_we_o), '0);
    checkOutput("rst_ub_addr", DATA_W'(ub_addr_o), '0);
    checkOutput("rst_ub_wdata", ub_wdata_o, '0);
    checkOutput("rst_rd_valid", DATA_W'(rd_valid_o), '0);
    checkOutput("rst_rd_data", rd_data_o, '0);

    // Four back-to-back reads 0x010..0x013, returned at grant+3.
    doReset();
    for (int k = 0; k < 8; k++) begin
      nextCycle();
      applyStimulus(1'b1, k < 4, ADDR_W'(16 + k), 1'b0, NO_ADDR, NO_DATA, 1'b0, NO_ADDR, NO_DATA);
      checkOutput("rd_gnt", DATA_W'(rd_gnt_o), DATA_W'(k < 4));
      checkOutput("rd_ub_en", DATA_W'(ub_en_o), DATA_W'(k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) begin
        checkOutput("rd_ub_we", DATA_W'(ub_we_o), '0);
        checkOutput("rd_ub_addr", DATA_W'(ub_addr_o), DATA_W'(16 + k - 1));
      end
      checkOutput("rd_valid", DATA_W'(rd_valid_o), DATA_W'(k >= 3 && k <= 6));
      checkOutput("rd_data", rd_data_o, (k < 3) ? '0 : DATA_W'(16 + ((k <= 6) ? k - 3 : 3)));
    end

    // Both writers held, read idle: HW, AW, HW, AW.
    doReset();
    for (int k = 0; k < 6; k++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b0, NO_ADDR, k < 4, HW_ADDR, HW_DATA, k < 4, AW_ADDR, AW_DATA);
      checkOutput("wr_hw_gnt", DATA_W'(hw_gnt_o), DATA_W'(k < 4 && (k % 2) == 0));
      checkOutput("wr_aw_gnt", DATA_W'(aw_gnt_o), DATA_W'(k < 4 && (k % 2) == 1));
      checkOutput("wr_rd_gnt", DATA_W'(rd_gnt_o), '0);
      if (k >= 1 && k <= 4) begin
        checkOutput("wr_ub_en", DATA_W'(ub_en_o), DATA_W'(1));
        checkOutput("wr_ub_we", DATA_W'(ub_we_o), DATA_W'(1));
        checkOutput("wr_ub_addr", DATA_W'(ub_addr_o), DATA_W'(((k - 1) % 2 == 0) ? HW_ADDR : AW_ADDR));
        checkOutput("wr_ub_wdata", ub_wdata_o, ((k - 1) % 2 == 0) ? HW_DATA : AW_DATA);
      end
      if (k == 5) begin
        checkOutput("idle_ub_en", DATA_W'(ub_en_o), '0);
        checkOutput("idle_ub_we", DATA_W'(ub_we_o), '0);
        checkOutput("idle_ub_addr_hold", DATA_W'(ub_addr_o), DATA_W'(AW_ADDR));
        checkOutput("idle_ub_wdata_hold", ub_wdata_o, AW_DATA);
      end
    end

    // Reads held, host writer held: forced slots at cycles 15 and 31.
    doReset();
    for (int k = 0; k < 40; k++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b1, 12'h020, k <= 31, HW_ADDR, HW_DATA, 1'b0, NO_ADDR, NO_DATA);
      expHw = (k == 15) || (k == 31);
      checkOutput("st1_hw_gnt", DATA_W'(hw_gnt_o), DATA_W'(expHw));
      checkOutput("st1_rd_gnt", DATA_W'(rd_gnt_o), DATA_W'(!expHw));
      if (k == 16 || k == 32) begin
        checkOutput("st1_ub_we", DATA_W'(ub_we_o), DATA_W'(1));
        checkOutput("st1_ub_addr", DATA_W'(ub_addr_o), DATA_W'(HW_ADDR));
        checkOutput("st1_ub_wdata", ub_wdata_o, HW_DATA);
      end
      if (k == 17) begin
        checkOutput("st1_ub_we_rd", DATA_W'(ub_we_o), '0);
        checkOutput("st1_ub_addr_rd", DATA_W'(ub_addr_o), DATA_W'(12'h020));
      end
    end
`ifdef UB_ARB_STATS_EN
    nextCycle();
    checkOutput("stat_forced", DATA_W'(stat_forced_o), DATA_W'(2));
    checkOutput("stat_wr_stall", DATA_W'(stat_wr_stall_o), DATA_W'(30));
    checkOutput("stat_rd_stall", DATA_W'(stat_rd_stall_o), DATA_W'(2));
`endif

    // Reads held, both writers held: HW at 15, AW at 16, reads resume at 17.
    doReset();
    for (int k = 0; k < 20; k++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b1, 12'h030, 1'b1, HW_ADDR, HW_DATA, 1'b1, AW_ADDR, AW_DATA);
      expHw = (k == 15);
      expAw = (k == 16);
      expRd = !(expHw || expAw);
      checkOutput("st2_hw_gnt", DATA_W'(hw_gnt_o), DATA_W'(expHw));
      checkOutput("st2_aw_gnt", DATA_W'(aw_gnt_o), DATA_W'(expAw));
      checkOutput("st2_rd_gnt", DATA_W'(rd_gnt_o), DATA_W'(expRd));
      if (k == 17) begin
        checkOutput("st2_ub_we", DATA_W'(ub_we_o), DATA_W'(1));
        checkOutput("st2_ub_addr", DATA_W'(ub_addr_o), DATA_W'(AW_ADDR));
        checkOutput("st2_ub_wdata", ub_wdata_o, AW_DATA);
      end
    end

    // Read granted, then a one-cycle reset: the in-flight read must never return.
    doReset();
    nextCycle();
    applyStimulus(1'b1, 1'b1, 12'h033, 1'b0, NO_ADDR, NO_DATA, 1'b0, NO_ADDR, NO_DATA);
    checkOutput("mr_rd_gnt", DATA_W'(rd_gnt_o), DATA_W'(1));
    nextCycle();
    applyStimulus(1'b0, 1'b1, 12'h034, 1'b1, HW_ADDR, HW_DATA, 1'b1, AW_ADDR, AW_DATA);
    checkOutput("mr_gated_rd_gnt", DATA_W'(rd_gnt_o), '0);
    checkOutput("mr_gated_hw_gnt", DATA_W'(hw_gnt_o), '0);
    checkOutput("mr_gated_aw_gnt", DATA_W'(aw_gnt_o), '0);
    checkOutput("mr_cmd_before_rst", DATA_W'(ub_en_o), DATA_W'(1));
    for (int k = 2; k < 6; k++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b0, NO_ADDR, 1'b0, NO_ADDR, NO_DATA, 1'b0, NO_ADDR, NO_DATA);
      checkOutput("mr_ub_en", DATA_W'(ub_en_o), '0);
      checkOutput("mr_ub_we", DATA_W'(ub_we_o), '0);
      checkOutput("mr_ub_addr", DATA_W'(ub_addr_o), '0);
      checkOutput("mr_ub_wdata", ub_wdata_o, '0);
      checkOutput("mr_rd_valid", DATA_W'(rd_valid_o), '0);
      checkOutput("mr_rd_data", rd_data_o, '0);
    end
    nextCycle();
    applyStimulus(1'b1, 1'b0, NO_ADDR, 1'b1, HW_ADDR, HW_DATA, 1'b0, NO_ADDR, NO_DATA);
    checkOutput("mr_resume_hw_gnt", DATA_W'(hw_gnt_o), DATA_W'(1));
    nextCycle();
    applyStimulus(1'b1, 1'b0, NO_ADDR, 1'b0, NO_ADDR, NO_DATA, 1'b0, NO_ADDR, NO_DATA);
    checkOutput("mr_resume_ub_we", DATA_W'(ub_we_o), DATA_W'(1));
    checkOutput("mr_resume_ub_addr", DATA_W'(ub_addr_o), DATA_W'(HW_ADDR));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
